// File: rtl/crossbar_rr_scheduler_if.sv
// Request/grant bundle between requesters and the crossbar round-robin scheduler.
// Optional o_grant_cnt field exists only when SCHED_GRANT_CNT_EN is defined.
interface crossbar_rr_scheduler_if #(
  parameter int NUM_INPUT_DATA  = 32,
  parameter int NUM_OUTPUT_DATA = 8
);
  localparam int DEST_W = $clog2(NUM_OUTPUT_DATA);

  // Handshake: a requester raises i_req_valid[k] with a stable i_req_dest field and
  // holds both until its burst is over; o_grant[k] is the per-beat "ready" -- each
  // cycle it is high, input k drives one beat into the crossbar. Dropping valid
  // ends the burst at the next edge without another beat.
  logic                                  i_en;
  logic [NUM_INPUT_DATA-1:0]             i_req_valid;
  logic [NUM_INPUT_DATA*DEST_W-1:0]      i_req_dest;
  logic [NUM_INPUT_DATA-1:0]             o_grant;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd;
  logic [NUM_OUTPUT_DATA-1:0]            o_busy;
`ifdef SCHED_GRANT_CNT_EN
  logic [NUM_OUTPUT_DATA*8-1:0]          o_grant_cnt;

  modport master (output i_en, i_req_valid, i_req_dest,
                  input  o_grant, o_cmd, o_busy, o_grant_cnt);
  modport slave  (input  i_en, i_req_valid, i_req_dest,
                  output o_grant, o_cmd, o_busy, o_grant_cnt);
`else
  modport master (output i_en, i_req_valid, i_req_dest,
                  input  o_grant, o_cmd, o_busy);
  modport slave  (input  i_en, i_req_valid, i_req_dest,
                  output o_grant, o_cmd, o_busy);
`endif
endinterface

// File: rtl/crossbar_rr_scheduler.sv
// Per-output round-robin burst scheduler driving a one-hot crossbar command bus.
// Define SCHED_GRANT_CNT_EN to add saturating per-output burst counters (o_grant_cnt).
module crossbar_rr_scheduler #(
  parameter int NUM_INPUT_DATA  = 32,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int BURST_LEN       = 4
) (
  input logic clk,
  input logic rst,
  crossbar_rr_scheduler_if.slave bus
);
  localparam int DEST_W = $clog2(NUM_OUTPUT_DATA);
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int IDX_W  = $clog2(NUM_INPUT_DATA);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e             state_q [NUM_OUTPUT_DATA];
  state_e             state_d [NUM_OUTPUT_DATA];
  logic [IDX_W-1:0]   owner_q [NUM_OUTPUT_DATA];
  logic [IDX_W-1:0]   owner_d [NUM_OUTPUT_DATA];
  logic [IDX_W-1:0]   ptr_q   [NUM_OUTPUT_DATA];
  logic [IDX_W-1:0]   ptr_d   [NUM_OUTPUT_DATA];
  logic [CNT_W-1:0]   cnt_q   [NUM_OUTPUT_DATA];
  logic [CNT_W-1:0]   cnt_d   [NUM_OUTPUT_DATA];

  logic [NUM_OUTPUT_DATA-1:0] win_vld;
  logic [IDX_W-1:0]           win_idx [NUM_OUTPUT_DATA];

  logic [NUM_INPUT_DATA-1:0]                 grant_q, grant_d;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] cmd_q, cmd_d;
  logic [NUM_OUTPUT_DATA-1:0]                busy_q, busy_d;

`ifdef SCHED_GRANT_CNT_EN
  logic [7:0] gcnt_q [NUM_OUTPUT_DATA];
  logic [7:0] gcnt_d [NUM_OUTPUT_DATA];
  logic [NUM_OUTPUT_DATA*8-1:0] gcnt_flat;
`endif

  // Round-robin search: first requester for output j starting just after ptr_j.
  always_comb begin
    win_vld = '0;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      win_idx[j] = '0;
      for (int i = 1; i <= NUM_INPUT_DATA; i++) begin
        int k;
        k = int'(ptr_q[j]) + i;
        if (k >= NUM_INPUT_DATA) k = k - NUM_INPUT_DATA;
        if (!win_vld[j] && bus.i_req_valid[k] &&
            (bus.i_req_dest[k*DEST_W +: DEST_W] == DEST_W'(j))) begin
          win_vld[j] = 1'b1;
          win_idx[j] = IDX_W'(k);
        end
      end
    end
  end

  // Per-output FSM; with i_en low every piece of state simply holds.
  always_comb begin
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      cnt_d[j]   = cnt_q[j];
`ifdef SCHED_GRANT_CNT_EN
      gcnt_d[j]  = gcnt_q[j];
`endif
      if (bus.i_en) begin
        unique case (state_q[j])
          IDLE: begin
            if (win_vld[j]) begin
              state_d[j] = LOCK;
              owner_d[j] = win_idx[j];
              ptr_d[j]   = win_idx[j];
              cnt_d[j]   = CNT_W'(BURST_LEN);
`ifdef SCHED_GRANT_CNT_EN
              if (gcnt_q[j] != 8'hFF) gcnt_d[j] = gcnt_q[j] + 8'd1;
`endif
            end
          end
          LOCK: begin
            // cnt counts the beat currently on the bus, so 1 means it was the last.
            if ((cnt_q[j] == CNT_W'(1)) || !bus.i_req_valid[owner_q[j]]) begin
              state_d[j] = IDLE;
              cnt_d[j]   = '0;
            end else begin
              cnt_d[j] = cnt_q[j] - CNT_W'(1);
            end
          end
          default: state_d[j] = IDLE;
        endcase
      end
    end
  end

  // Registered outputs follow the next state; i_en low masks the beat but keeps busy.
  always_comb begin
    grant_d = '0;
    cmd_d   = '0;
    busy_d  = '0;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      if (state_d[j] == LOCK) begin
        busy_d[j] = 1'b1;
        if (bus.i_en) begin
          grant_d[owner_d[j]] = 1'b1;
          cmd_d[int'(owner_d[j])*NUM_OUTPUT_DATA + j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= IDX_W'(NUM_INPUT_DATA - 1);
        cnt_q[j]   <= '0;
`ifdef SCHED_GRANT_CNT_EN
        gcnt_q[j]  <= '0;
`endif
      end
      grant_q <= '0;
      cmd_q   <= '0;
      busy_q  <= '0;
    end else begin
      for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
        cnt_q[j]   <= cnt_d[j];
`ifdef SCHED_GRANT_CNT_EN
        gcnt_q[j]  <= gcnt_d[j];
`endif
      end
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_grant = grant_q;
  assign bus.o_cmd   = cmd_q;
  assign bus.o_busy  = busy_q;

`ifdef SCHED_GRANT_CNT_EN
  always_comb begin
    gcnt_flat = '0;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) gcnt_flat[j*8 +: 8] = gcnt_q[j];
  end
  assign bus.o_grant_cnt = gcnt_flat;
`endif
endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// Bench for crossbar_rr_scheduler: vector table, directed corner sequences and
// random traffic against a burst-level reference model (SCHED_GRANT_CNT_EN aware).
module tb_crossbar_rr_scheduler;
  localparam int NI = 32;
  localparam int NO = 8;
  localparam int BL = 4;
  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crossbar_rr_scheduler_if #(.NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO)) bus ();
  crossbar_rr_scheduler #(.NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO), .BURST_LEN(BL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: who owns each output and how many beats it has had so far.
  int m_owner [NO];
  int m_beats [NO];
  int m_last  [NO];
  int m_gcnt  [NO];
  logic [NI-1:0]    exp_grant;
  logic [NI*NO-1:0] exp_cmd;
  logic [NO-1:0]    exp_busy;

  typedef struct { int in_idx; int out_idx; int cmd_bit; } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int dest_of(int k);
    return int'(bus.i_req_dest[k*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NO; j++) begin
      m_owner[j] = -1;
      m_beats[j] = 0;
      m_last[j]  = NI - 1;
      m_gcnt[j]  = 0;
    end
    exp_grant = '0;
    exp_cmd   = '0;
    exp_busy  = '0;
  endtask

  // Applies the scheduling rules to the inputs present before the coming edge.
  task automatic model_step();
    exp_grant = '0;
    exp_cmd   = '0;
    exp_busy  = '0;
    for (int j = 0; j < NO; j++) begin
      if (bus.i_en) begin
        if (m_owner[j] < 0) begin
          for (int s = 1; s <= NI; s++) begin
            int k;
            k = (m_last[j] + s) % NI;
            if (bus.i_req_valid[k] && dest_of(k) == j) begin
              m_owner[j] = k;
              m_last[j]  = k;
              m_beats[j] = 1;
              if (m_gcnt[j] < 255) m_gcnt[j]++;
              break;
            end
          end
        end else if (m_beats[j] >= BL || !bus.i_req_valid[m_owner[j]]) begin
          m_owner[j] = -1;
        end else begin
          m_beats[j]++;
        end
      end
      if (m_owner[j] >= 0) begin
        exp_busy[j] = 1'b1;
        if (bus.i_en) begin
          exp_grant[m_owner[j]] = 1'b1;
          exp_cmd[m_owner[j]*NO + j] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef SCHED_GRANT_CNT_EN
    logic [NO*8-1:0] e;
    for (int j = 0; j < NO; j++) e[j*8 +: 8] = 8'(m_gcnt[j]);
    check(name, bus.o_grant_cnt, e);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_grant", bus.o_grant, exp_grant);
    check("model_cmd", bus.o_cmd, exp_cmd);
    check("model_busy", bus.o_busy, exp_busy);
    check_cnt("model_gcnt");
  endtask

  task automatic set_req(input int k, input int j, input bit v);
    bus.i_req_valid[k] = v;
    bus.i_req_dest[k*DW +: DW] = DW'(j);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_en = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_dest = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", bus.o_grant, '0);
    check("rst_cmd", bus.o_cmd, '0);
    check("rst_busy", bus.o_busy, '0);
    check_cnt("rst_gcnt");
    rst = 1'b0;
  endtask

  function automatic bit is_owner(int k);
    for (int j = 0; j < NO; j++) if (m_owner[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] e;
    int beats;
    int owner_seq [4];

    vecs[0] = '{3, 5, 29};
    vecs[1] = '{0, 0, 0};
    vecs[2] = '{31, 7, 255};
    vecs[3] = '{17, 2, 138};
    vecs[4] = '{8, 3, 67};
    vecs[5] = '{22, 6, 182};
    owner_seq = '{0, 7, 20, 0};

    do_reset();

    // Single-requester bursts: BL beats on one command bit, then an idle cycle.
    foreach (vecs[v]) begin
      set_req(vecs[v].in_idx, vecs[v].out_idx, 1'b1);
      for (int c = 1; c <= BL; c++) begin
        tick();
        e = '0; e[vecs[v].in_idx] = 1'b1;
        check("vec_grant", bus.o_grant, e);
        e = '0; e[vecs[v].cmd_bit] = 1'b1;
        check("vec_cmd", bus.o_cmd, e);
        e = '0; e[vecs[v].out_idx] = 1'b1;
        check("vec_busy", bus.o_busy, e);
      end
      tick();
      check("vec_end_grant", bus.o_grant, '0);
      check("vec_end_busy", bus.o_busy, '0);
      set_req(vecs[v].in_idx, vecs[v].out_idx, 1'b0);
      tick();
    end

    // Contention on out2 from the reset pointer: owners 0,7,20,0 with 1-cycle gaps.
    do_reset();
    set_req(0, 2, 1'b1); set_req(7, 2, 1'b1); set_req(20, 2, 1'b1);
    for (int c = 1; c <= 19; c++) begin
      tick();
      e = '0;
      if ((c - 1) % 5 != 4) e[owner_seq[(c - 1) / 5]] = 1'b1;
      check("t2_owner", bus.o_grant, e);
    end
    bus.i_req_valid = '0;
    tick(); tick();

    // Parallel: in k -> out k-1 all granted together.
    for (int k = 1; k <= 8; k++) set_req(k, k - 1, 1'b1);
    tick();
    check("t3_grant", bus.o_grant, 256'h1FE);
    e = '0;
    for (int k = 1; k <= 8; k++) e[k*8 + (k - 1)] = 1'b1;
    check("t3_cmd", bus.o_cmd, e);
    check("t3_busy", bus.o_busy, 256'hFF);
    bus.i_req_valid = '0;
    tick(); tick();

    // Early drop after the second beat.
    beats = 0;
    set_req(9, 4, 1'b1);
    tick(); beats += int'(bus.o_grant[9]);
    tick(); beats += int'(bus.o_grant[9]);
    set_req(9, 4, 1'b0);
    tick(); beats += int'(bus.o_grant[9]);
    check("t4_busy_after_drop", bus.o_busy[4], 1'b0);
    tick(); beats += int'(bus.o_grant[9]);
    check("t4_beats", beats, 2);

    // Enable stall during the burst of in4 -> out6.
    beats = 0;
    set_req(4, 6, 1'b1);
    tick(); beats += int'(bus.o_grant[4]);
    bus.i_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_stall_grant", bus.o_grant[4], 1'b0);
      check("t5_stall_busy", bus.o_busy[6], 1'b1);
    end
    bus.i_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); beats += int'(bus.o_grant[4]);
    end
    set_req(4, 6, 1'b0);
    check("t5_beats", beats, 4);
    tick();

    // Async reset mid-burst; pointer must restart so input 0 wins over input 7.
    set_req(0, 2, 1'b1);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    check("t6_grant", bus.o_grant, '0);
    check("t6_cmd", bus.o_cmd, '0);
    check("t6_busy", bus.o_busy, '0);
`ifdef SCHED_GRANT_CNT_EN
    check("t6_gcnt", bus.o_grant_cnt, '0);
`endif
    model_reset();
    bus.i_req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 2, 1'b1); set_req(7, 2, 1'b1);
    tick();
    check("t6_restart_owner", bus.o_grant, 256'h1);
    bus.i_req_valid = '0;
    tick(); tick();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (bus.i_req_valid[k]) begin
          if ($urandom_range(0, 29) == 0) bus.i_req_valid[k] = 1'b0;
        end else if (!is_owner(k) && $urandom_range(0, 3) == 0) begin
          set_req(k, int'($urandom_range(0, NO - 1)), 1'b1);
        end
      end
      bus.i_en = ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
